// File: rtl/add_round_keys_seq_pkg.sv
// Shared definitions for the sequential AddRoundKey block.
//   ARK_BLOCK_W : default block width (state / subkey / result)
//   ARK_LANE_W  : default number of bits combined per cycle
//   ark_state_e : controller state encoding
package add_round_keys_pkg;

   localparam int ARK_BLOCK_W = 128;
   localparam int ARK_LANE_W  = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } ark_state_e;

endpackage

// File: rtl/add_round_keys_seq_if.sv
// Block-level handshake bundle for add_round_keys_seq.
//   in_valid/in_ready   : input block offer / accept
//   state, subkey       : block operands, BLOCK_W bits each
//   bypass              : pass state through unchanged
//   out_valid/out_ready : result offer / accept
//   out                 : result, BLOCK_W bits
// master = upstream/downstream environment, slave = the AddRoundKey block.
interface add_round_keys_seq_if
   import add_round_keys_pkg::*;
#(
   parameter int BLOCK_W = ARK_BLOCK_W
);
   logic               in_valid;
   logic               in_ready;
   logic [BLOCK_W-1:0] state;
   logic [BLOCK_W-1:0] subkey;
   logic               bypass;
   logic               out_valid;
   logic               out_ready;
   logic [BLOCK_W-1:0] out;

   modport master (
      output in_valid, state, subkey, bypass, out_ready,
      input  in_ready, out_valid, out
   );

   modport slave (
      input  in_valid, state, subkey, bypass, out_ready,
      output in_ready, out_valid, out
   );
endinterface

// File: rtl/add_round_keys_seq_lane.sv
// One lane of AddRoundKey: res = st ^ key, or st when bypass is set.
//   st, key : LANE_W-bit operands
//   bypass  : ignore key
//   res     : LANE_W-bit result
module add_round_key_lane
   import add_round_keys_pkg::*;
#(
   parameter int LANE_W = ARK_LANE_W
) (
   input  logic [LANE_W-1:0] st,
   input  logic [LANE_W-1:0] key,
   input  logic              bypass,
   output logic [LANE_W-1:0] res
);

   assign res = st ^ (bypass ? '0 : key);

endmodule

// File: rtl/add_round_keys_seq.sv
// Sequential AddRoundKey: a captured block is combined with its round key
// one LANE_W-wide lane per cycle through a single shared lane XOR.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : handshake bundle (slave side), see add_round_keys_seq_if
//   busy       : high while lanes are being processed
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for a block, in_ready high
// ST_BUSY | writing lane cnt of the result each cycle
// ST_DONE | result presented, held until out_ready
module add_round_keys_seq
   import add_round_keys_pkg::*;
#(
   parameter int BLOCK_W = ARK_BLOCK_W,
   parameter int LANE_W  = ARK_LANE_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   add_round_keys_seq_if.slave  bus,
   output logic                 busy
);

   localparam int BEATS = (LANE_W == 0) ? 1 : BLOCK_W / LANE_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

   if (LANE_W == 0) begin : g_bad_lane_zero
      $error("add_round_keys_seq: LANE_W must be non-zero");
   end else if (BLOCK_W % LANE_W != 0) begin : g_bad_lane_mult
      $error("add_round_keys_seq: BLOCK_W must be a multiple of LANE_W");
   end

   ark_state_e         fsm;
   logic [CNT_W-1:0]   cnt;
   logic [BLOCK_W-1:0] st_q;
   logic [BLOCK_W-1:0] key_q;
   logic               bypass_q;
   logic [BLOCK_W-1:0] res_q;
   logic               out_valid_q;
   logic               busy_q;

   logic [LANE_W-1:0]  st_lane;
   logic [LANE_W-1:0]  key_lane;
   logic [LANE_W-1:0]  lane_res;
   logic               accept;

   // in_ready looks through to out_ready in DONE so a new block can be
   // taken on the same edge the current result leaves.
   assign bus.in_ready  = rst_n & ((fsm == ST_IDLE) |
                                   ((fsm == ST_DONE) & bus.out_ready));
   assign accept        = bus.in_valid & bus.in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out       = res_q;
   assign busy          = busy_q;

   always_comb begin
      st_lane  = '0;
      key_lane = '0;
      for (int k = 0; k < BEATS; k++) begin
         if (cnt == CNT_W'(k)) begin
            st_lane  = st_q[k*LANE_W +: LANE_W];
            key_lane = key_q[k*LANE_W +: LANE_W];
         end
      end
   end

   add_round_key_lane #(
      .LANE_W (LANE_W)
   ) u_lane (
      .st     (st_lane),
      .key    (key_lane),
      .bypass (bypass_q),
      .res    (lane_res)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm         <= ST_IDLE;
         cnt         <= '0;
         st_q        <= '0;
         key_q       <= '0;
         bypass_q    <= 1'b0;
         res_q       <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (fsm)
            ST_IDLE: begin
               if (accept) begin
                  st_q     <= bus.state;
                  key_q    <= bus.subkey;
                  bypass_q <= bus.bypass;
                  cnt      <= '0;
                  busy_q   <= 1'b1;
                  fsm      <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               for (int k = 0; k < BEATS; k++) begin
                  if (cnt == CNT_W'(k)) begin
                     res_q[k*LANE_W +: LANE_W] <= lane_res;
                  end
               end
               if (cnt == LAST) begin
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
                  fsm         <= ST_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  if (bus.in_valid) begin
                     st_q     <= bus.state;
                     key_q    <= bus.subkey;
                     bypass_q <= bus.bypass;
                     cnt      <= '0;
                     busy_q   <= 1'b1;
                     fsm      <= ST_BUSY;
                  end else begin
                     fsm <= ST_IDLE;
                  end
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               fsm         <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
